// File: rtl/arithm_pkg.sv
// Shared constants and types for the arithm_div signed fixed-point divider.
package arithm_pkg;

  localparam int W_DEF    = 14;
  localparam int FRAC_DEF = 14;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Counter must hold every iteration index plus one for W+FRAC restoring steps.
  function automatic int iter_cnt_w(input int w, input int frac);
    return $clog2(w + frac + 1);
  endfunction

  localparam int CNT_W = iter_cnt_w(W_DEF, FRAC_DEF);

endpackage

// File: rtl/arithm_udiv_core.sv
// Unsigned iterative restoring divider: one quotient bit per enabled cycle, MSB first.
module arithm_udiv_core
  import arithm_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                start,
  input  logic [W+FRAC-1:0]   dividend,
  input  logic [W-1:0]        divisor,
  output logic [W+FRAC-1:0]   quotient,
  output logic                done
);

  localparam int N  = W + FRAC;
  localparam int CW = iter_cnt_w(W, FRAC);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  div_r;
  logic [N-1:0]  quot;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          ge;

  // The remainder stays below the divisor, so W bits plus the incoming bit suffice.
  always_comb begin
    shifted = {rem, quot[N-1]};
    diff    = shifted - {1'b0, div_r};
    ge      = (shifted >= {1'b0, div_r});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      div_r <= '0;
      quot  <= '0;
    end else if (ce) begin
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        rem   <= '0;
        div_r <= divisor;
        quot  <= dividend;
      end else if (busy) begin
        rem  <= ge ? W'(diff) : W'(shifted);
        quot <= {quot[N-2:0], ge};
        cnt  <= cnt + 1'b1;
        if (cnt == LAST)
          busy <= 1'b0;
      end
    end
  end

  // Marks the cycle performing the final step, so the caller can leave CALC on that same edge.
  assign done     = busy && (cnt == LAST);
  assign quotient = quot;

endmodule

// File: rtl/arithm_div.sv
// Signed fixed-point divider Q = trunc((O << FRAC) / C) with valid/ready handshake.
// Optional macro ARITHM_DIV_SAT_EN saturates q on overflow instead of wrapping.
module arithm_div
  import arithm_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] o_in,
  input  logic [W-1:0] c_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] q,
  output logic         dz,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N = W + FRAC;
  localparam logic [N-1:0] POS_LIM = N'((1 << (W - 1)) - 1);
  localparam logic [N-1:0] NEG_LIM = N'(1 << (W - 1));
  localparam logic [W-1:0] Q_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN   = {1'b1, {(W-1){1'b0}}};

  state_t state, next_state;

  logic         accept;
  logic         c_zero;
  logic         core_start;
  logic         core_done;
  logic [W:0]   o_ext, c_ext;
  logic [W-1:0] o_mag, c_mag;
  logic [N-1:0] dividend;
  logic [N-1:0] mag, neg_mag;
  logic         sign_r, o_zero_r, dz_r;
  logic [W-1:0] q_wrap, q_fix;
  logic         ovf_mag, ovf_fix;

  // Magnitudes come from a sign-extended copy so that -2^(W-1) maps to 2^(W-1) exactly.
  always_comb begin
    o_ext      = {o_in[W-1], o_in};
    c_ext      = {c_in[W-1], c_in};
    o_mag      = W'(o_in[W-1] ? -o_ext : o_ext);
    c_mag      = W'(c_in[W-1] ? -c_ext : c_ext);
    dividend   = {o_mag, {FRAC{1'b0}}};
    c_zero     = (c_in == '0);
    accept     = (state == IDLE) && in_valid && in_ready;
    core_start = accept && !c_zero;
  end

  arithm_udiv_core #(
    .W    (W),
    .FRAC (FRAC)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .start    (core_start),
    .dividend (dividend),
    .divisor  (c_mag),
    .quotient (mag),
    .done     (core_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (ce)
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept)    next_state = c_zero ? FIX : CALC;
      CALC: if (core_done) next_state = FIX;
      FIX:                 next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Sign fix-up and range check; the negative side may reach one step further than the positive.
  always_comb begin
    neg_mag = -mag;
    q_wrap  = W'(sign_r ? neg_mag : mag);
    ovf_mag = sign_r ? (mag > NEG_LIM) : (mag > POS_LIM);
    if (dz_r) begin
      ovf_fix = !o_zero_r;
      q_fix   = o_zero_r ? '0 : (sign_r ? Q_MIN : Q_MAX);
    end else begin
      ovf_fix = ovf_mag;
`ifdef ARITHM_DIV_SAT_EN
      q_fix   = ovf_mag ? (sign_r ? Q_MIN : Q_MAX) : q_wrap;
`else
      q_fix   = q_wrap;
`endif
    end
  end

  // in_ready is registered so it only rises on the first enabled edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r    <= 1'b0;
      o_zero_r  <= 1'b0;
      dz_r      <= 1'b0;
      q         <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (ce) begin
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r   <= o_in[W-1] ^ c_in[W-1];
            o_zero_r <= (o_in == '0);
            dz_r     <= c_zero;
          end
        end
        FIX: begin
          q         <= q_fix;
          dz        <= dz_r;
          ovf       <= ovf_fix;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
